// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard: forwarding
// select encoding, register index width and the pipeline shadow-entry layouts.
package hazard_scoreboard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // Producer view of an in-flight instruction, tracked for EX, MEM and WB.
    typedef struct packed {
        logic             valid;
        logic             we;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } shadow_t;

    // The EX entry also remembers its own sources so it can pick forwarding.
    typedef struct packed {
        shadow_t          dst;
        logic             re1;
        logic             re2;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } ex_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decoder-side bundle into the scoreboard and the stall/forwarding results out.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    import hazard_scoreboard_pkg::*;

    logic             id_valid;
    logic             id_re1;
    logic             id_re2;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_we;
    logic [REG_W-1:0] id_rd;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_re1, id_re2, id_rs1, id_rs2,
               id_we, id_rd, id_is_load, flush,
        input  stall, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_re1, id_re2, id_rs1, id_rs2,
               id_we, id_rd, id_is_load, flush,
        output stall, fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Combinational RAW detector: does this producer entry write the given source?
// Register x0 is hard-wired to zero and therefore never produces a match.
module hazard_match
    import hazard_scoreboard_pkg::*;
(
    input  shadow_t          i_entry,
    input  logic [REG_W-1:0] i_src,
    input  logic             i_re,
    output logic             o_match
);

    logic w_unused_is_load;

    assign w_unused_is_load = i_entry.is_load;

    assign o_match = i_entry.valid & i_entry.we & i_re
                   & (i_entry.rd != '0) & (i_entry.rd == i_src);

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow EX/MEM/WB occupancy tracker producing the load-use stall, the EX
// operand forwarding selects and a saturating count of stalled cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  sb
);

    ex_entry_t        r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    ex_entry_t w_ex_next;
    logic      w_ld_hit1, w_ld_hit2, w_stall;
    logic      w_ex_re1, w_ex_re2;
    logic      w_mem_a, w_wb_a, w_mem_b, w_wb_b;
    fwd_sel_t  w_fwd_a, w_fwd_b;

    // Load-use: the ID instruction needs a value the load in EX has not fetched yet.
    hazard_match u_ld_rs1 (.i_entry(r_ex.dst), .i_src(sb.id_rs1), .i_re(sb.id_re1), .o_match(w_ld_hit1));
    hazard_match u_ld_rs2 (.i_entry(r_ex.dst), .i_src(sb.id_rs2), .i_re(sb.id_re2), .o_match(w_ld_hit2));

    assign w_stall = sb.id_valid & r_ex.dst.is_load & (w_ld_hit1 | w_ld_hit2) & ~sb.flush;

    // Forwarding looks only at registered state, so an invalid EX reads nothing.
    assign w_ex_re1 = r_ex.dst.valid & r_ex.re1;
    assign w_ex_re2 = r_ex.dst.valid & r_ex.re2;

    hazard_match u_mem_a (.i_entry(r_mem), .i_src(r_ex.rs1), .i_re(w_ex_re1), .o_match(w_mem_a));
    hazard_match u_wb_a  (.i_entry(r_wb),  .i_src(r_ex.rs1), .i_re(w_ex_re1), .o_match(w_wb_a));
    hazard_match u_mem_b (.i_entry(r_mem), .i_src(r_ex.rs2), .i_re(w_ex_re2), .o_match(w_mem_b));
    hazard_match u_wb_b  (.i_entry(r_wb),  .i_src(r_ex.rs2), .i_re(w_ex_re2), .o_match(w_wb_b));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (w_mem_a)     w_fwd_a = FWD_MEM;
        else if (w_wb_a) w_fwd_a = FWD_WB;
        if (w_mem_b)     w_fwd_b = FWD_MEM;
        else if (w_wb_b) w_fwd_b = FWD_WB;
    end

    always_comb begin
        w_ex_next = '0;
        if (!(sb.flush || w_stall)) begin
            w_ex_next.dst.valid   = sb.id_valid;
            w_ex_next.dst.we      = sb.id_we;
            w_ex_next.dst.rd      = sb.id_rd;
            w_ex_next.dst.is_load = sb.id_is_load;
            w_ex_next.re1         = sb.id_re1;
            w_ex_next.re2         = sb.id_re2;
            w_ex_next.rs1         = sb.id_rs1;
            w_ex_next.rs2         = sb.id_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments let WB, MEM and EX shift together on one edge.
            r_wb  <= r_mem;
            r_mem <= r_ex.dst;
            r_ex  <= w_ex_next;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign sb.stall     = w_stall;
    assign sb.fwd_a     = w_fwd_a;
    assign sb.fwd_b     = w_fwd_b;
    assign sb.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector scoreboard bench: a 16-bit-counter and a 2-bit-counter DUT
// see the same stimulus; a negedge monitor checks each queued expectation.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(16)) sb16 ();
    hazard_scoreboard_if #(.CNT_W(2))  sb2  ();

    hazard_scoreboard #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .sb(sb16));
    hazard_scoreboard #(.CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .sb(sb2));

    assign sb2.id_valid   = sb16.id_valid;
    assign sb2.id_re1     = sb16.id_re1;
    assign sb2.id_re2     = sb16.id_re2;
    assign sb2.id_rs1     = sb16.id_rs1;
    assign sb2.id_rs2     = sb16.id_rs2;
    assign sb2.id_we      = sb16.id_we;
    assign sb2.id_rd      = sb16.id_rd;
    assign sb2.id_is_load = sb16.id_is_load;
    assign sb2.flush      = sb16.flush;

    typedef struct packed {
        logic             valid, re1, re2;
        logic [REG_W-1:0] rs1, rs2;
        logic             we;
        logic [REG_W-1:0] rd;
        logic             is_load, flush;
    } stim_t;

    typedef struct {
        int         cyc;
        logic       stall;
        logic [1:0] fa, fb;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic stim_t nop();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t alu(input logic we, input logic [REG_W-1:0] rd,
                                  input logic re1, input logic [REG_W-1:0] rs1,
                                  input logic re2, input logic [REG_W-1:0] rs2);
        stim_t s = '0;
        s.valid = 1'b1; s.we = we; s.rd = rd;
        s.re1 = re1; s.rs1 = rs1; s.re2 = re2; s.rs2 = rs2;
        return s;
    endfunction

    function automatic stim_t ld(input logic [REG_W-1:0] rd);
        stim_t s = alu(1'b1, rd, 1'b0, '0, 1'b0, '0);
        s.is_load = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    // Apply one cycle of inputs after the edge and queue what that cycle must show.
    task automatic step(input logic rst, input stim_t s, input logic es,
                        input logic [1:0] efa, input logic [1:0] efb, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = rst;
        sb16.id_valid   = s.valid;
        sb16.id_re1     = s.re1;
        sb16.id_re2     = s.re2;
        sb16.id_rs1     = s.rs1;
        sb16.id_rs2     = s.rs2;
        sb16.id_we      = s.we;
        sb16.id_rd      = s.rd;
        sb16.id_is_load = s.is_load;
        sb16.flush      = s.flush;
        e.cyc = cyc; e.stall = es; e.fa = efa; e.fb = efb; e.cnt = ecnt;
        q.push_back(e);
        cyc++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("stall",     e.cyc, int'(sb16.stall),     int'(e.stall));
            check("fwd_a",     e.cyc, int'(sb16.fwd_a),     int'(e.fa));
            check("fwd_b",     e.cyc, int'(sb16.fwd_b),     int'(e.fb));
            check("stall_cnt", e.cyc, int'(sb16.stall_cnt), e.cnt);
            check("sat_cnt",   e.cyc, int'(sb2.stall_cnt),  (e.cnt > 3) ? 3 : e.cnt);
        end
    end

    initial begin
        stim_t s;
        sb16.id_valid = 0; sb16.id_re1 = 0; sb16.id_re2 = 0; sb16.id_rs1 = '0;
        sb16.id_rs2 = '0; sb16.id_we = 0; sb16.id_rd = '0; sb16.id_is_load = 0;
        sb16.flush = 0;

        step(0, nop(), 0, FWD_RF, FWD_RF, 0);
        step(1, nop(), 0, FWD_RF, FWD_RF, 0);
        // Back-to-back ALU RAW on x5
        step(1, alu(1, 5, 1, 1, 1, 2), 0, FWD_RF,  FWD_RF, 0);
        step(1, alu(1, 8, 1, 5, 1, 6), 0, FWD_RF,  FWD_RF, 0);
        step(1, nop(),                 0, FWD_MEM, FWD_RF, 0);
        // Distance-2 RAW on rs2, then x5 in both MEM and WB
        step(1, alu(1, 5, 0, 0, 0, 0), 0, FWD_RF, FWD_RF,  0);
        step(1, nop(),                 0, FWD_RF, FWD_RF,  0);
        step(1, alu(0, 0, 1, 3, 1, 5), 0, FWD_RF, FWD_RF,  0);
        step(1, nop(),                 0, FWD_RF, FWD_WB,  0);
        step(1, alu(1, 5, 0, 0, 0, 0), 0, FWD_RF, FWD_RF,  0);
        step(1, alu(1, 5, 0, 0, 0, 0), 0, FWD_RF, FWD_RF,  0);
        step(1, alu(0, 0, 1, 5, 1, 5), 0, FWD_RF, FWD_RF,  0);
        step(1, nop(),                 0, FWD_MEM, FWD_MEM, 0);
        // Load-use on x7: one stall, bubble, then WB forwarding
        step(1, ld(7),                 0, FWD_RF, FWD_RF, 0);
        step(1, alu(1, 9, 1, 7, 1, 2), 1, FWD_RF, FWD_RF, 0);
        step(1, alu(1, 9, 1, 7, 1, 2), 0, FWD_RF, FWD_RF, 1);
        step(1, nop(),                 0, FWD_WB, FWD_RF, 1);
        // Reader two behind the load: no stall, WB forwarding
        step(1, ld(7),                 0, FWD_RF, FWD_RF, 1);
        step(1, nop(),                 0, FWD_RF, FWD_RF, 1);
        step(1, alu(0, 0, 1, 7, 0, 0), 0, FWD_RF, FWD_RF, 1);
        step(1, nop(),                 0, FWD_WB, FWD_RF, 1);
        // x0 masking
        step(1, ld(0),                 0, FWD_RF, FWD_RF, 1);
        step(1, alu(0, 0, 1, 0, 1, 0), 0, FWD_RF, FWD_RF, 1);
        step(1, nop(),                 0, FWD_RF, FWD_RF, 1);
        // Read-enable masking with a JAL-like instruction
        step(1, ld(7),                 0, FWD_RF, FWD_RF, 1);
        step(1, alu(1, 1, 0, 7, 0, 7), 0, FWD_RF, FWD_RF, 1);
        step(1, nop(),                 0, FWD_RF, FWD_RF, 1);
        // Flush wins over a load-use condition
        step(1, ld(7),                 0, FWD_RF, FWD_RF, 1);
        s = alu(1, 3, 1, 7, 1, 7);
        s.flush = 1'b1;
        step(1, s,                     0, FWD_RF, FWD_RF, 1);
        step(1, nop(),                 0, FWD_RF, FWD_RF, 1);
        // Reset mid-stream with MEM and WB valid
        step(1, alu(1, 4, 0, 0, 0, 0), 0, FWD_RF, FWD_RF, 1);
        step(1, alu(1, 5, 0, 0, 0, 0), 0, FWD_RF, FWD_RF, 1);
        step(1, alu(0, 0, 1, 4, 1, 5), 0, FWD_RF, FWD_RF, 1);
        step(0, alu(0, 0, 1, 4, 1, 5), 0, FWD_RF, FWD_RF, 0);
        step(1, alu(0, 0, 1, 4, 1, 5), 0, FWD_RF, FWD_RF, 0);
        // Five load-use stalls: 16-bit count reaches 5, 2-bit count holds at 3
        step(1, ld(7),                 0, FWD_RF, FWD_RF, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, alu(0, 0, 1, 7, 0, 0), 1, FWD_RF, FWD_RF, k);
            step(1, alu(0, 0, 1, 7, 0, 0), 0, FWD_RF, FWD_RF, k + 1);
            step(1, ld(7),                 0, FWD_WB, FWD_RF, k + 1);
        end
        step(1, nop(),                 0, FWD_RF, FWD_RF, 5);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
